aging_lottery_arbiter: RTL and testbench

Starvation-bounded random arbiter sharing one resource among `NUM_REQS` requesters. An `lfsr_8bit` instance picks a random scan start each arbitration. Per-requester age counters force a grant to any requester that has waited `AGE_LIMIT` cycles. It replaces open-loop random arbitration wherever a guaranteed worst-case wait is required.

---
 rtl/arb_pkg.sv | 43 ++++
 rtl/lfsr_8bit.sv | 25 ++
 rtl/aging_lottery_arbiter.sv | 142 ++++++++++++++
 tb/tb_aging_lottery_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the aging lottery arbiter.
package arb_pkg;

    // Upper bound on requester count; scan helper works on vectors of this width.
    localparam int unsigned MAX_REQS  = 16;
    localparam int unsigned MAX_IDX_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } scan_t;

    // Index width for a requester count, never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of vec scanning upward from start, wrapping at n (power of two).
    function automatic scan_t first_from(input logic [MAX_REQS-1:0]  vec,
                                         input logic [MAX_IDX_W-1:0] start,
                                         input int unsigned          n);
        scan_t                res;
        logic [MAX_IDX_W-1:0] mask;
        logic [MAX_IDX_W-1:0] j;
        res  = '0;
        mask = MAX_IDX_W'(n - 1);
        // Walk downward so the lowest offset from start wins the last assignment.
        for (int k = MAX_REQS - 1; k >= 0; k--) begin
            j = (start + MAX_IDX_W'(k)) & mask;
            if (($unsigned(k) < n) && vec[j]) begin
                res.found = 1'b1;
                res.idx   = j;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lfsr_8bit.sv
// 8-bit Fibonacci LFSR (x^8 + x^6 + x^5 + x^4 + 1), loaded with seed while in reset.
module lfsr_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seed,
    output logic [7:0] lfsr_out
);

    logic [7:0] lfsr_q;
    logic       fb;

    assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    // Shift every cycle; seed must be non-zero to avoid the all-zero lock state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= {lfsr_q[6:0], fb};
        end
    end

    assign lfsr_out = lfsr_q;

endmodule

// File: rtl/aging_lottery_arbiter.sv
// Random-start arbiter with per-requester aging that bounds the worst-case wait.
module aging_lottery_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned NUM_REQS  = 4,
    parameter  int unsigned MAX_HOLD  = 4,
    parameter  int unsigned AGE_LIMIT = 8,
    localparam int unsigned IDX_W     = idx_w(NUM_REQS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          lfsr_seed,
    input  logic [NUM_REQS-1:0] req,
    output logic [NUM_REQS-1:0] grant,
    output logic                grant_valid,
    output logic [IDX_W-1:0]    grant_id,
    output logic                starve_event
);

    localparam int unsigned       AGE_W     = $clog2(AGE_LIMIT + 1);
    localparam int unsigned       HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [AGE_W-1:0]  AGE_MAX   = AGE_W'(AGE_LIMIT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e          state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NUM_REQS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]    grant_id_q, grant_id_d;
    logic                starve_q, starve_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [AGE_W-1:0]    age_q [NUM_REQS];
    logic [AGE_W-1:0]    age_d [NUM_REQS];

    logic [7:0]          seed_fix;
    logic [7:0]          lfsr_out;
    logic [7-IDX_W:0]    unused_lfsr_hi;

    logic                arb_en;
    logic [NUM_REQS-1:0] others;
    logic [NUM_REQS-1:0] cand;
    logic [NUM_REQS-1:0] aged;
    scan_t               forced;
    scan_t               rand_pick;
    scan_t               pick;

    // An all-zero seed would lock the LFSR, so substitute 1.
    assign seed_fix = (lfsr_seed == 8'h00) ? 8'h01 : lfsr_seed;

    lfsr_8bit u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .seed     (seed_fix),
        .lfsr_out (lfsr_out)
    );

    assign unused_lfsr_hi = lfsr_out[7:IDX_W];

    // Candidate set and winner selection: aged requesters first, else random start.
    always_comb begin
        aged   = '0;
        others = req & ~grant_q;
        // Drop the holder only when someone else wants the resource.
        cand   = (|others) ? others : req;
        for (int i = 0; i < NUM_REQS; i++) begin
            aged[i] = cand[i] && (age_q[i] == AGE_MAX);
        end
        arb_en    = (state_q == IDLE) || !req[grant_id_q] || (hold_cnt_q == HOLD_LAST);
        forced    = first_from(MAX_REQS'(aged), MAX_IDX_W'(rr_ptr_q), NUM_REQS);
        rand_pick = first_from(MAX_REQS'(cand), MAX_IDX_W'(lfsr_out[IDX_W-1:0]), NUM_REQS);
        pick      = forced.found ? forced : rand_pick;
    end

    // FSM, hold counter, grant and round-robin pointer next state.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        starve_d   = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        if (arb_en) begin
            if (pick.found) begin
                state_d    = GRANT;
                hold_cnt_d = '0;
                grant_id_d = IDX_W'(pick.idx);
                grant_d    = NUM_REQS'(1) << pick.idx;
                starve_d   = forced.found;
                rr_ptr_d   = IDX_W'(pick.idx) + IDX_W'(1);
            end else begin
                state_d    = IDLE;
                hold_cnt_d = '0;
                grant_d    = '0;
                grant_id_d = '0;
            end
        end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
    end

    // Age counts consecutive waiting cycles; any grant (new or held) clears it.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            age_d[i] = age_q[i];
            if (!req[i] || grant_d[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] != AGE_MAX) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            starve_q   <= 1'b0;
            rr_ptr_q   <= '0;
            for (int i = 0; i < NUM_REQS; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            starve_q   <= starve_d;
            rr_ptr_q   <= rr_ptr_d;
            for (int i = 0; i < NUM_REQS; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign grant        = grant_q;
    assign grant_valid  = |grant_q;
    assign grant_id     = grant_id_q;
    assign starve_event = starve_q;

endmodule

// File: tb/tb_aging_lottery_arbiter.sv
// Randomized bench for aging_lottery_arbiter against a cycle-level behavioural model.
module tb_aging_lottery_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;
    localparam int AL = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   lfsr_seed = 8'hA5;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic         starve_event;

    int total = 0;
    int bad   = 0;

    // Model state: holder index (-1 when idle), cycles held, waiting ages, scan pointer, LFSR.
    int           m_holder;
    int           m_hold;
    int           m_rr;
    int           m_age [N];
    logic [7:0]   m_lfsr;
    logic [N-1:0] e_grant;
    logic [1:0]   e_id;
    logic         e_starve;

    aging_lottery_arbiter #(
        .NUM_REQS  (N),
        .MAX_HOLD  (MH),
        .AGE_LIMIT (AL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lfsr_seed    (lfsr_seed),
        .req          (req),
        .grant        (grant),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .starve_event (starve_event)
    );

    always #5 clk = ~clk;

    task automatic model_reset(input logic [7:0] seed);
        m_holder = -1;
        m_hold   = 0;
        m_rr     = 0;
        for (int i = 0; i < N; i++) m_age[i] = 0;
        m_lfsr   = (seed == 8'h00) ? 8'h01 : seed;
        e_grant  = '0;
        e_id     = '0;
        e_starve = 1'b0;
    endtask

    // Predict the outputs after the next rising edge given the requests before it.
    task automatic model_step(input logic [N-1:0] r);
        bit           arb;
        logic [N-1:0] others;
        logic [N-1:0] cand;
        int           win;
        int           j;
        arb = (m_holder < 0) || (r[m_holder] == 1'b0) || (m_hold == MH - 1);
        e_starve = 1'b0;
        if (!arb) begin
            win = m_holder;
            m_hold++;
        end else begin
            others = r;
            if (m_holder >= 0) others[m_holder] = 1'b0;
            cand = (others != '0) ? others : r;
            win = -1;
            for (int k = 0; k < N; k++) begin
                j = (m_rr + k) % N;
                if (win < 0 && cand[j] && m_age[j] == AL) win = j;
            end
            if (win >= 0) begin
                e_starve = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    j = (int'(m_lfsr) % N + k) % N;
                    if (win < 0 && cand[j]) win = j;
                end
            end
            m_hold   = 0;
            m_holder = win;
            if (win >= 0) m_rr = (win + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (!r[i] || i == win) m_age[i] = 0;
            else if (m_age[i] < AL) m_age[i] = m_age[i] + 1;
        end
        m_lfsr   = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        e_grant  = (win >= 0) ? N'(1 << win) : '0;
        e_id     = (win >= 0) ? 2'(win) : 2'd0;
    endtask

    // Assert reset (checking the asynchronous clear), hold for two edges, release off-edge.
    task automatic apply_reset(input logic [7:0] seed);
        lfsr_seed = seed;
        rst_n = 1'b0;
        #2;
        total++;
        if (grant !== '0 || grant_valid !== 1'b0 || grant_id !== 2'd0 || starve_event !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got grant=%b valid=%b id=%0d starve=%b, want all zero",
                     grant, grant_valid, grant_id, starve_event);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (grant !== '0 || grant_valid !== 1'b0 || grant_id !== 2'd0 || starve_event !== 1'b0) begin
            bad++;
            $display("FAIL reset_held: got grant=%b valid=%b id=%0d starve=%b, want all zero",
                     grant, grant_valid, grant_id, starve_event);
        end
        rst_n = 1'b1;
        model_reset(seed);
    endtask

    task automatic test_reset();
        req = 4'b1111;
        apply_reset(8'hA5);
        for (int c = 0; c < 6; c++) begin
            model_step(req);
            @(posedge clk);
            #1;
            total++;
            if (grant !== e_grant || grant_id !== e_id || starve_event !== e_starve ||
                grant_valid !== (|e_grant) || (c == 0 && grant_valid !== 1'b1)) begin
                bad++;
                $display("FAIL reset_first cyc=%0d: got grant=%b id=%0d starve=%b valid=%b, want grant=%b id=%0d starve=%b",
                         c, grant, grant_id, starve_event, grant_valid, e_grant, e_id, e_starve);
            end
        end
        // Mid-grant reset must clear outputs without waiting for an edge.
        apply_reset(8'hA5);
    endtask

    task automatic test_sole();
        apply_reset(8'h5A);
        req = 4'b0100;
        for (int c = 0; c < 12; c++) begin
            model_step(req);
            @(posedge clk);
            #1;
            total++;
            if (grant !== 4'b0100 || grant_id !== 2'd2 || starve_event !== 1'b0 ||
                grant_valid !== 1'b1 || grant !== e_grant) begin
                bad++;
                $display("FAIL sole cyc=%0d: got grant=%b id=%0d starve=%b valid=%b, want grant=0100 id=2 starve=0",
                         c, grant, grant_id, starve_event, grant_valid);
            end
        end
    endtask

    task automatic test_early_release();
        logic [N-1:0] want;
        apply_reset(8'h3C);
        req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            // Third edge: holder released on hold cycle 1, resource hands straight over.
            if (c == 2) req = 4'b0010;
            want = (c == 2) ? 4'b0010 : 4'b0100;
            model_step(req);
            @(posedge clk);
            #1;
            total++;
            if (grant !== want || grant_valid !== 1'b1 || grant !== e_grant || grant_id !== e_id) begin
                bad++;
                $display("FAIL early_release cyc=%0d: got grant=%b valid=%b id=%0d, want grant=%b valid=1",
                         c, grant, grant_valid, grant_id, want);
            end
        end
    endtask

    task automatic test_saturation();
        int wait_c [N];
        int seen [N];
        int max_wait = 0;
        int run = 0;
        int max_run = 0;
        int prev_id = -1;
        int n_starve = 0;
        apply_reset(8'hA5);
        req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            wait_c[i] = 0;
            seen[i] = 0;
        end
        for (int c = 0; c < 2000; c++) begin
            model_step(req);
            @(posedge clk);
            #1;
            total++;
            if (grant !== e_grant || grant_id !== e_id || starve_event !== e_starve ||
                grant_valid !== (|e_grant)) begin
                bad++;
                $display("FAIL saturation cyc=%0d: got grant=%b id=%0d starve=%b valid=%b, want grant=%b id=%0d starve=%b",
                         c, grant, grant_id, starve_event, grant_valid, e_grant, e_id, e_starve);
            end
            if (starve_event === 1'b1) n_starve++;
            for (int i = 0; i < N; i++) begin
                if (grant[i] === 1'b1) begin
                    wait_c[i] = 0;
                    seen[i]++;
                end else begin
                    wait_c[i]++;
                    if (wait_c[i] > max_wait) max_wait = wait_c[i];
                end
            end
            if (grant_valid === 1'b1 && int'(grant_id) == prev_id) run++;
            else run = (grant_valid === 1'b1) ? 1 : 0;
            prev_id = (grant_valid === 1'b1) ? int'(grant_id) : -1;
            if (run > max_run) max_run = run;
        end
        total++;
        if (max_wait > AL + N * MH) begin
            bad++;
            $display("FAIL sat_max_wait: got %0d cycles, want <= %0d", max_wait, AL + N * MH);
        end
        total++;
        if (max_run > MH) begin
            bad++;
            $display("FAIL sat_max_run: got %0d cycles, want <= %0d", max_run, MH);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (seen[i] == 0) begin
                bad++;
                $display("FAIL sat_coverage: index %0d got 0 grant cycles, want > 0", i);
            end
        end
        $display("saturation: max_wait=%0d max_run=%0d starve_pulses=%0d", max_wait, max_run, n_starve);
    endtask

    task automatic test_random();
        logic [7:0] seed;
        seed = 8'($urandom_range(1, 255));
        apply_reset(seed);
        req = 4'($urandom);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            model_step(req);
            @(posedge clk);
            #1;
            total++;
            if (grant !== e_grant || grant_id !== e_id || starve_event !== e_starve ||
                grant_valid !== (|e_grant)) begin
                bad++;
                $display("FAIL random seed=%h cyc=%0d: got grant=%b id=%0d starve=%b valid=%b, want grant=%b id=%0d starve=%b",
                         seed, c, grant, grant_id, starve_event, grant_valid, e_grant, e_id, e_starve);
            end
        end
    endtask

    // A zero seed must behave exactly like seed 1 (model is seeded with 1 for both).
    task automatic test_zero_seed();
        logic [N-1:0] trace [300];
        for (int c = 0; c < 300; c++) trace[c] = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b1111;
        for (int pass = 0; pass < 2; pass++) begin
            apply_reset(pass == 0 ? 8'h00 : 8'h01);
            for (int c = 0; c < 300; c++) begin
                req = trace[c];
                model_step(req);
                @(posedge clk);
                #1;
                total++;
                if (grant !== e_grant || grant_id !== e_id || starve_event !== e_starve ||
                    grant_valid !== (|e_grant)) begin
                    bad++;
                    $display("FAIL zero_seed pass=%0d cyc=%0d: got grant=%b id=%0d starve=%b, want grant=%b id=%0d starve=%b",
                             pass, c, grant, grant_id, starve_event, e_grant, e_id, e_starve);
                end
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_sole();
        test_early_release();
        test_saturation();
        test_random();
        test_zero_seed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
